// File: rtl/debug_pkg.sv
// Shared types and constants for the debug dump sequencer.
package debug_pkg;

   localparam int unsigned NUM_RB_WORDS   = 32;
   localparam int unsigned BYTES_PER_WORD = 4;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_CAPTURE,
      ST_SEND,
      ST_WAIT_TX,
      ST_DONE
   } dump_state_t;

   typedef enum logic [1:0] {
      PH_PC,
      PH_RB,
      PH_DM
   } dump_phase_t;

endpackage

// File: rtl/word_serializer.sv
// Holds one word and presents its bytes LSB-first, one per next strobe.
module word_serializer
   import debug_pkg::*;
#(
   parameter int unsigned BYTE   = 8,
   parameter int unsigned NBYTES = BYTES_PER_WORD
)(
   input  logic                   i_clock,
   input  logic                   i_reset,
   input  logic                   i_load,
   input  logic                   i_next,
   input  logic [BYTE*NBYTES-1:0] i_data,
   output logic [BYTE-1:0]        o_byte,
   output logic                   o_last
);

   localparam int unsigned DWORD = BYTE * NBYTES;
   localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   logic [DWORD-1:0] shift_q;
   logic [IDX_W-1:0] idx_q;

   // Load takes priority; each next strobe exposes the following byte.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         shift_q <= '0;
         idx_q   <= '0;
         o_byte  <= '0;
         o_last  <= 1'b0;
      end else if (i_load) begin
         o_byte  <= i_data[BYTE-1:0];
         shift_q <= i_data >> BYTE;
         idx_q   <= '0;
         o_last  <= (NBYTES == 1);
      end else if (i_next) begin
         o_byte  <= shift_q[BYTE-1:0];
         shift_q <= shift_q >> BYTE;
         idx_q   <= idx_q + IDX_W'(1);
         o_last  <= ((idx_q + IDX_W'(1)) == IDX_W'(NBYTES - 1));
      end
   end

endmodule

// File: rtl/debug_dump_sequencer.sv
// Streams PC, register bank and data memory to the debug UART, 4 bytes/word.
// Optional DUMP_CHECKSUM_EN appends one XOR checksum byte to the frame.
module debug_dump_sequencer
   import debug_pkg::*;
#(
   parameter int unsigned BYTE     = 8,
   parameter int unsigned DWORD    = 32,
   parameter int unsigned RB_ADDR  = 5,
   parameter int unsigned ADDR     = 7,
   parameter int unsigned DM_WORDS = 32
)(
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic [DWORD-1:0]   i_pc_value,
   input  logic [DWORD-1:0]   i_rb_data,
   input  logic [DWORD-1:0]   i_dm_data,
   input  logic               i_tx_done,
   output logic [RB_ADDR-1:0] o_rb_addr,
   output logic               o_rb_enable,
   output logic               o_rb_read_enable,
   output logic [ADDR-1:0]    o_dm_addr,
   output logic               o_dm_enable,
   output logic               o_dm_read_enable,
   output logic [BYTE-1:0]    o_tx_data,
   output logic               o_tx_start,
   output logic               o_busy,
   output logic               o_done
);

   localparam int unsigned TOTAL_WORDS = 1 + NUM_RB_WORDS + DM_WORDS;
   localparam int unsigned WCNT_W      = $clog2(TOTAL_WORDS);
   localparam int unsigned NBYTES      = DWORD / BYTE;

   dump_state_t       state;
   dump_phase_t       phase;
   logic [WCNT_W-1:0] wcnt;
   logic              ser_load_c;
   logic              ser_next_c;
   logic [DWORD-1:0]  ser_data_c;
   logic              ser_last;
   logic              last_word_c;
`ifdef DUMP_CHECKSUM_EN
   logic [BYTE-1:0]   csum;
   logic              csum_sent;
`endif

   word_serializer #(
      .BYTE   (BYTE),
      .NBYTES (NBYTES)
   ) u_serializer (
      .i_clock (i_clock),
      .i_reset (i_reset),
      .i_load  (ser_load_c),
      .i_next  (ser_next_c),
      .i_data  (ser_data_c),
      .o_byte  (o_tx_data),
      .o_last  (ser_last)
   );

   // Serializer strobes line up with the FSM edges that enter SEND.
   always_comb begin
      ser_load_c  = 1'b0;
      ser_next_c  = 1'b0;
      ser_data_c  = i_pc_value;
      last_word_c = (wcnt == WCNT_W'(TOTAL_WORDS - 1));
      case (state)
         ST_LOAD: begin
            if (phase == PH_PC) ser_load_c = 1'b1;
         end
         ST_CAPTURE: begin
            ser_load_c = 1'b1;
            ser_data_c = (phase == PH_RB) ? i_rb_data : i_dm_data;
         end
         ST_WAIT_TX: begin
            ser_next_c = i_tx_done && !ser_last;
`ifdef DUMP_CHECKSUM_EN
            if (csum_sent) begin
               ser_next_c = 1'b0;
            end else if (i_tx_done && ser_last && last_word_c) begin
               ser_load_c = 1'b1;
               ser_data_c = DWORD'(csum);
            end
`endif
         end
         default: ;
      endcase
   end

   // Dump sequencing FSM with registered port controls.
   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         state            <= ST_IDLE;
         phase            <= PH_PC;
         wcnt             <= '0;
         o_rb_addr        <= '0;
         o_rb_enable      <= 1'b0;
         o_rb_read_enable <= 1'b0;
         o_dm_addr        <= '0;
         o_dm_enable      <= 1'b0;
         o_dm_read_enable <= 1'b0;
         o_tx_start       <= 1'b0;
         o_busy           <= 1'b0;
         o_done           <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
         csum             <= '0;
         csum_sent        <= 1'b0;
`endif
      end else begin
         case (state)
            ST_IDLE: begin
               if (i_start) begin
                  state  <= ST_LOAD;
                  phase  <= PH_PC;
                  wcnt   <= '0;
                  o_busy <= 1'b1;
`ifdef DUMP_CHECKSUM_EN
                  csum      <= '0;
                  csum_sent <= 1'b0;
`endif
               end
            end
            ST_LOAD: begin
               if (phase == PH_PC) begin
                  state      <= ST_SEND;
                  o_tx_start <= 1'b1;
               end else begin
                  state <= ST_CAPTURE;
               end
            end
            ST_CAPTURE: begin
               state            <= ST_SEND;
               o_tx_start       <= 1'b1;
               o_rb_enable      <= 1'b0;
               o_rb_read_enable <= 1'b0;
               o_dm_enable      <= 1'b0;
               o_dm_read_enable <= 1'b0;
            end
            ST_SEND: begin
               state      <= ST_WAIT_TX;
               o_tx_start <= 1'b0;
`ifdef DUMP_CHECKSUM_EN
               csum       <= csum ^ o_tx_data;
`endif
            end
            ST_WAIT_TX: begin
               if (i_tx_done) begin
`ifdef DUMP_CHECKSUM_EN
                  if (csum_sent) begin
                     state  <= ST_DONE;
                     o_done <= 1'b1;
                  end else
`endif
                  if (!ser_last) begin
                     state      <= ST_SEND;
                     o_tx_start <= 1'b1;
                  end else if (!last_word_c) begin
                     state <= ST_LOAD;
                     wcnt  <= wcnt + WCNT_W'(1);
                     case (phase)
                        PH_PC: begin
                           phase            <= PH_RB;
                           o_rb_addr        <= '0;
                           o_rb_enable      <= 1'b1;
                           o_rb_read_enable <= 1'b1;
                        end
                        PH_RB: begin
                           if (o_rb_addr == RB_ADDR'(NUM_RB_WORDS - 1)) begin
                              phase            <= PH_DM;
                              o_dm_addr        <= '0;
                              o_dm_enable      <= 1'b1;
                              o_dm_read_enable <= 1'b1;
                           end else begin
                              o_rb_addr        <= o_rb_addr + RB_ADDR'(1);
                              o_rb_enable      <= 1'b1;
                              o_rb_read_enable <= 1'b1;
                           end
                        end
                        default: begin
                           o_dm_addr        <= o_dm_addr + ADDR'(1);
                           o_dm_enable      <= 1'b1;
                           o_dm_read_enable <= 1'b1;
                        end
                     endcase
                  end else begin
`ifdef DUMP_CHECKSUM_EN
                     state      <= ST_SEND;
                     o_tx_start <= 1'b1;
                     csum_sent  <= 1'b1;
`else
                     state  <= ST_DONE;
                     o_done <= 1'b1;
`endif
                  end
               end
            end
            ST_DONE: begin
               state  <= ST_IDLE;
               o_done <= 1'b0;
               o_busy <= 1'b0;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Scoreboard bench for debug_dump_sequencer (DM_WORDS=4); honours DUMP_CHECKSUM_EN.
module tb_debug_dump_sequencer;

   localparam int unsigned DM_WORDS = 4;
   localparam int unsigned NWORDS   = 33 + DM_WORDS;
`ifdef DUMP_CHECKSUM_EN
   localparam int unsigned FRAME    = 4 * NWORDS + 1;
`else
   localparam int unsigned FRAME    = 4 * NWORDS;
`endif
   localparam logic [31:0] PC_VAL   = 32'h1234_5678;
   localparam logic [31:0] GARBAGE  = 32'hDEAD_BEEF;

   logic        i_clock;
   logic        i_reset;
   logic        i_start;
   logic [31:0] i_pc_value;
   logic [31:0] i_rb_data;
   logic [31:0] i_dm_data;
   logic        i_tx_done;
   logic [4:0]  o_rb_addr;
   logic        o_rb_enable;
   logic        o_rb_read_enable;
   logic [6:0]  o_dm_addr;
   logic        o_dm_enable;
   logic        o_dm_read_enable;
   logic [7:0]  o_tx_data;
   logic        o_tx_start;
   logic        o_busy;
   logic        o_done;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];
   int  byte_cnt = 0;
   int  done_cnt = 0;
   int  tx_cnt   = 0;
   bit  spurious = 1'b0;
   bit  done_follow = 1'b0;
   bit  rb_en_prev = 1'b0;
   bit  dm_en_prev = 1'b0;

   debug_dump_sequencer #(.DM_WORDS(DM_WORDS)) dut (
      .i_clock          (i_clock),
      .i_reset          (i_reset),
      .i_start          (i_start),
      .i_pc_value       (i_pc_value),
      .i_rb_data        (i_rb_data),
      .i_dm_data        (i_dm_data),
      .i_tx_done        (i_tx_done),
      .o_rb_addr        (o_rb_addr),
      .o_rb_enable      (o_rb_enable),
      .o_rb_read_enable (o_rb_read_enable),
      .o_dm_addr        (o_dm_addr),
      .o_dm_enable      (o_dm_enable),
      .o_dm_read_enable (o_dm_read_enable),
      .o_tx_data        (o_tx_data),
      .o_tx_start       (o_tx_start),
      .o_busy           (o_busy),
      .o_done           (o_done)
   );

   initial i_clock = 1'b0;
   always #5 i_clock = ~i_clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   // Expected frame: PC, RB[n]=n, DM[n]=A0000000+n, LSB first, optional XOR byte.
   task automatic push_frame();
      logic [31:0] w;
      logic [7:0]  x;
      x = 8'h00;
      for (int i = 0; i < int'(NWORDS); i++) begin
         if (i == 0)       w = PC_VAL;
         else if (i <= 32) w = 32'(i - 1);
         else              w = 32'hA000_0000 + 32'(i - 33);
         for (int b = 0; b < 4; b++) begin
            exp_q.push_back(w[8*b +: 8]);
            x = x ^ w[8*b +: 8];
         end
      end
`ifdef DUMP_CHECKSUM_EN
      exp_q.push_back(x);
`endif
   endtask

   // UART model (done 3 cycles after start), memory models, scoreboard pop.
   always @(negedge i_clock) begin
      if (!i_reset) begin
         tx_cnt      = 0;
         i_tx_done   = 1'b0;
         done_follow = 1'b0;
      end else begin
         i_tx_done = 1'b0;
         if (tx_cnt != 0) begin
            tx_cnt--;
            if (tx_cnt == 0) i_tx_done = 1'b1;
         end
         if (spurious && (o_rb_enable || o_dm_enable)) i_tx_done = 1'b1;
         if (o_tx_start) begin
            byte_cnt++;
            chk("tx_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("tx_byte", 32'(o_tx_data), 32'(exp_q.pop_front()));
            tx_cnt = 3;
         end
         if (done_follow) chk("busy_after_done", 32'(o_busy), 32'd0);
         done_follow = 1'b0;
         if (o_done) begin
            done_cnt++;
            chk("busy_at_done", 32'(o_busy), 32'd1);
            done_follow = 1'b1;
         end
      end
      // Read data valid only for the single cycle after the enabled LOAD edge.
      if (o_rb_enable && o_rb_read_enable && rb_en_prev) i_rb_data = 32'(o_rb_addr);
      else i_rb_data = GARBAGE;
      if (o_dm_enable && o_dm_read_enable && dm_en_prev) i_dm_data = 32'hA000_0000 + 32'(o_dm_addr);
      else i_dm_data = GARBAGE;
      rb_en_prev = o_rb_enable && o_rb_read_enable;
      dm_en_prev = o_dm_enable && o_dm_read_enable;
   end

   task automatic pulse_start();
      @(negedge i_clock) i_start = 1'b1;
      @(negedge i_clock) i_start = 1'b0;
   endtask

   task automatic wait_bytes(input int target, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 2000 && !ok; c++) begin
         @(posedge i_clock);
         if (byte_cnt >= target) ok = 1'b1;
      end
   endtask

   task automatic run_frame(input bit perturb);
      int base;
      int dprev;
      bit ok;
      base  = byte_cnt;
      dprev = done_cnt;
      push_frame();
      spurious = perturb;
      pulse_start();
      chk("busy_cycle1", 32'(o_busy), 32'd1);
      chk("tx_start_cycle1", 32'(o_tx_start), 32'd0);
      @(negedge i_clock);
      chk("tx_start_cycle2", 32'(o_tx_start), 32'd1);
      chk("tx_data_cycle2", 32'(o_tx_data), 32'h78);
      if (perturb) begin
         wait_bytes(base + 20, ok);
         chk("reach_byte20", 32'(ok), 32'd1);
         pulse_start();
      end
      ok = 1'b0;
      for (int c = 0; c < 4000 && !ok; c++) begin
         @(posedge i_clock);
         if (done_cnt > dprev) ok = 1'b1;
      end
      chk("done_seen", 32'(ok), 32'd1);
      repeat (5) @(negedge i_clock);
      chk("frame_bytes", 32'(byte_cnt - base), 32'(FRAME));
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      chk("done_pulses", 32'(done_cnt - dprev), 32'd1);
      chk("idle_busy", 32'(o_busy), 32'd0);
      spurious = 1'b0;
   endtask

   initial begin
      int base;
      bit ok;
      i_reset    = 1'b0;
      i_start    = 1'b0;
      i_pc_value = PC_VAL;
      repeat (3) @(negedge i_clock);
      chk("reset_outputs", 32'({o_busy, o_done, o_tx_start, o_tx_data, o_rb_enable, o_rb_read_enable,
          o_rb_addr, o_dm_enable, o_dm_read_enable, o_dm_addr}), 32'd0);
      i_reset = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge i_clock);
         chk("idle_outputs", 32'({o_busy, o_done, o_tx_start, o_tx_data, o_rb_enable, o_rb_read_enable,
             o_rb_addr, o_dm_enable, o_dm_read_enable, o_dm_addr}), 32'd0);
      end
      chk("idle_tx_count", 32'(byte_cnt), 32'd0);

      run_frame(1'b0);
      run_frame(1'b1);

      // Abort mid-frame with reset after byte 50.
      base = byte_cnt;
      push_frame();
      pulse_start();
      wait_bytes(base + 50, ok);
      chk("reach_byte50", 32'(ok), 32'd1);
      @(negedge i_clock) i_reset = 1'b0;
      @(negedge i_clock);
      chk("abort_busy", 32'(o_busy), 32'd0);
      chk("abort_ctrl", 32'({o_tx_start, o_done, o_rb_enable, o_rb_read_enable, o_dm_enable, o_dm_read_enable}), 32'd0);
      i_reset = 1'b1;
      exp_q.delete();
      repeat (20) @(negedge i_clock);
      chk("abort_no_more_bytes", 32'(byte_cnt - base), 32'd50);
      chk("abort_idle_busy", 32'(o_busy), 32'd0);

      run_frame(1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/debug_dump_sequencer.md
# debug_dump_sequencer

Sequences the post-halt/post-step state dump of the pipeline to the host over the debug UART. On a start pulse it streams the PC, all 32 register-bank words, then `DM_WORDS` data-memory words, serialising each 32-bit word into four UART bytes with a tx_start/tx_done handshake. It sits between the debug unit, the datapath's register-bank/data-memory debug read ports and the UART transmitter. It owns those read ports and the UART TX side exclusively while busy.

## Interface
Parameters:
- `BYTE`, 8, UART byte width
- `DWORD`, 32, word width of PC / register bank / data memory
- `RB_ADDR`, 5, register-bank address width (32 registers)
- `ADDR`, 7, data-memory word address width
- `DM_WORDS`, 32, data-memory words dumped, range 1..2^ADDR

Ports:
- `i_clock`  in  1  single clock
- `i_reset`  in  1  synchronous, active-low reset
- `i_start`  in  1  one-cycle dump request
- `i_pc_value`  in  DWORD  current PC
- `i_rb_data`  in  DWORD  register-bank read data, 1-cycle read latency
- `i_dm_data`  in  DWORD  data-memory read data, 1-cycle read latency
- `i_tx_done`  in  1  UART byte-sent tick
- `o_rb_addr`  out  RB_ADDR  register-bank read address
- `o_rb_enable`, `o_rb_read_enable`  out  1  register-bank port enables
- `o_dm_addr`  out  ADDR  data-memory read address
- `o_dm_enable`, `o_dm_read_enable`  out  1  data-memory port enables
- `o_tx_data`  out  BYTE  byte to transmit
- `o_tx_start`  out  1  one-cycle transmit request
- `o_busy`  out  1  dump in progress
- `o_done`  out  1  one-cycle pulse after the last byte's tx_done

## Operation
- Sources in order: PC (1 word), RB 0..31, DM 0..DM_WORDS-1. Total frame = 4·(33+DM_WORDS) bytes (260 at default).
- Each word is sent LSB byte first: [7:0], [15:8], [23:16], [31:24].
- States:
  - IDLE: `i_start`=1 → LOAD; busy goes high.
  - LOAD: drive addr and both enables of the current source. PC needs no read, so LOAD captures `i_pc_value` directly → SEND.
  - CAPTURE: enables held; register read data at the end of the cycle → SEND.
  - SEND: `o_tx_start`=1 for one cycle with the current byte → WAIT_TX.
  - WAIT_TX: on `i_tx_done`:
    - if the byte index < 3 → SEND with the next byte;
    - else if words remain → LOAD with the next word;
    - else → DONE.
  - DONE: `o_done`=1 one cycle → IDLE.
- Enables are high only in LOAD/CAPTURE of the matching source, low otherwise. Addresses hold their last value.
- Word counter width ≥ clog2(33+DM_WORDS). The RB index wraps 31→DM phase; the DM address counts 0..DM_WORDS-1 with no wrap.
- `i_start` while busy is ignored. `i_tx_done` outside WAIT_TX is ignored.
- Reset at any point → IDLE immediately, no further `o_tx_start`, partial frame abandoned.

## Timing
- Reset values: all outputs 0; state IDLE; counters 0.
- `i_start` in cycle 0 → `o_busy`=1 and LOAD in cycle 1 → first `o_tx_start` (PC[7:0]) in cycle 2.
- RB/DM word: LOAD (c) → CAPTURE (c+1, data sampled at its rising edge end) → `o_tx_start` at c+2.
- Next byte's `o_tx_start` comes 1 cycle after `i_tx_done`. Next word's LOAD comes 1 cycle after the 4th byte's `i_tx_done`.
- `o_done` is asserted the cycle after the final `i_tx_done`. `o_busy` drops together with the return to IDLE (`o_busy` is low in the cycle after `o_done`).
- `o_tx_data` is stable from SEND until the next SEND.

## Configuration
- `DUMP_CHECKSUM_EN`:
  - Defined: after the last word, send one extra byte equal to the XOR of all frame bytes (SEND/WAIT_TX once more before DONE). Frame = 4·(33+DM_WORDS)+1 bytes. The accumulator clears at `i_start`.
  - Undefined: no accumulator, frame ends at the last DM byte.

## Structure
- Shared package `debug_pkg`: state encoding, source-phase encoding (PC/RB/DM), `NUM_RB_WORDS`=32, bytes-per-word constant.
- One sub-module, `word_serializer`: loads a DWORD, emits its bytes LSB-first under a next-byte strobe, and flags the last byte.

## Test plan
- Reset, idle 10 cycles → all outputs 0, no `o_tx_start`.
- PC=0x12345678, RB[n]=n, DM[n]=0xA0000000+n, DM_WORDS=4; `i_start`; TX model returns `i_tx_done` 3 cycles after each `o_tx_start` → 148 bytes:
  - first bytes 78 56 34 12 00 00 00 00 01 00 00 00;
  - last DM word 03 00 00 A0;
  - `o_done` pulses once.
- Same run with `DUMP_CHECKSUM_EN` → 149 bytes; last byte = XOR of the preceding 148.
- `i_start` re-pulsed mid-dump, plus spurious `i_tx_done` in LOAD → frame unchanged, byte count unchanged.
- `i_reset`=0 after byte 50 → next cycle IDLE with busy 0, no further bytes; new `i_start` restarts from PC byte 0.
- Read-latency check: RB data changes the cycle after CAPTURE → captured value is the one at the CAPTURE edge.
